// File: rtl/random_mwc_pkg.sv
// Shared constants, types and arithmetic helpers for the multi-stream MWC generator.
// With RANDOM_MWC_READBACK_EN defined, offsets 0x14/0x18 expose the raw z/w words.
package random_mwc_pkg;

  localparam logic [31:0] DEF_Z = 32'h159A_55E5;
  localparam logic [31:0] DEF_W = 32'h1F12_3BB5;

  // Register index = adr[4:2]
  localparam logic [2:0] OFF_OUT   = 3'd0;
  localparam logic [2:0] OFF_SEL   = 3'd1;
  localparam logic [2:0] OFF_ZSEED = 3'd2;
  localparam logic [2:0] OFF_WSEED = 3'd3;
  localparam logic [2:0] OFF_CTRL  = 3'd4;
  localparam logic [2:0] OFF_ZRB   = 3'd5;
  localparam logic [2:0] OFF_WRB   = 3'd6;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_READ = 3'd2,
    ST_CALC = 3'd3,
    ST_ACK  = 3'd4
  } state_e;

  typedef struct packed {
    logic [31:0] z;
    logic [31:0] w;
  } mwc_state_t;

  // 16x16 product plus a 16-bit carry never exceeds 32 bits.
  function automatic logic [31:0] mwc_step(input logic [31:0] x, input logic [15:0] mult);
    return ({16'b0, mult} * {16'b0, x[15:0]}) + {16'b0, x[31:16]};
  endfunction

  function automatic logic [31:0] mwc_out(input mwc_state_t s);
    return {s.z[15:0], 16'b0} + s.w;
  endfunction

endpackage

// File: rtl/rand_state_ram.sv
// Single-port synchronous-read state RAM holding one packed {z,w} word per stream.
// Read is read-first: a write in the same cycle returns the previous contents.
module rand_state_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/random_mwc_ms.sv
// Multi-stream multiply-with-carry generator behind a single-outstanding register slave.
// Optional raw z/w readback at 0x14/0x18 is built only when RANDOM_MWC_READBACK_EN is defined.
//
// state | meaning
// INIT  | writing default seeds to entry init_cnt, one entry per cycle
// IDLE  | waiting for a request; RAM address follows the selected stream
// READ  | RAM read of entry [stream] in flight
// CALC  | compute next state / read data, write RAM and control regs
// ACK   | one-cycle response with dat_o
module random_mwc_ms
  import random_mwc_pkg::*;
#(
  parameter int          NSTREAM = 1024,
  parameter int          SBITS   = $clog2(NSTREAM),
  parameter logic [15:0] Z_MULT  = 16'd36969,
  parameter logic [15:0] W_MULT  = 16'd18000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [4:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] dat_o
);

  localparam logic [2:0] S_INIT = ST_INIT;
  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_READ = ST_READ;
  localparam logic [2:0] S_CALC = ST_CALC;
  localparam logic [2:0] S_ACK  = ST_ACK;

  logic [2:0]       state;
  logic [SBITS-1:0] init_cnt;
  logic [SBITS-1:0] stream;
  logic             auto_en;
  logic             op_we;
  logic [2:0]       op_off;
  logic [31:0]      op_dat;
  logic [31:0]      rd_data;

  logic             ram_we;
  logic [SBITS-1:0] ram_addr;
  mwc_state_t       ram_wdata;
  mwc_state_t       ram_rdata;

  mwc_state_t       cur;
  mwc_state_t       adv;
  mwc_state_t       calc_wdata;
  logic             calc_wr;
  logic [31:0]      calc_rdata;

  // Byte lanes are not decoded; word registers only.
  logic unused_adr;
  assign unused_adr = ^adr_i[1:0];

  always_comb begin
    cur        = ram_rdata;
    adv.z      = mwc_step(cur.z, Z_MULT);
    adv.w      = mwc_step(cur.w, W_MULT);
    calc_wr    = 1'b0;
    calc_wdata = cur;
    calc_rdata = 32'b0;
    case (op_off)
      OFF_OUT: begin
        if (!op_we) calc_rdata = mwc_out(cur);
        if (op_we || auto_en) begin
          calc_wr    = 1'b1;
          calc_wdata = adv;
        end
      end
      OFF_SEL: begin
        if (!op_we) calc_rdata = 32'(stream);
      end
      OFF_ZSEED: begin
        if (op_we) begin
          calc_wr      = 1'b1;
          calc_wdata.z = (op_dat == 32'b0) ? DEF_Z : op_dat;
        end
      end
      OFF_WSEED: begin
        if (op_we) begin
          calc_wr      = 1'b1;
          calc_wdata.w = (op_dat == 32'b0) ? DEF_W : op_dat;
        end
      end
      OFF_CTRL: begin
        if (!op_we) calc_rdata = {31'b0, auto_en};
      end
`ifdef RANDOM_MWC_READBACK_EN
      OFF_ZRB: begin
        if (!op_we) calc_rdata = cur.z;
      end
      OFF_WRB: begin
        if (!op_we) calc_rdata = cur.w;
      end
`endif
      default: ;
    endcase
  end

  // Reset suppresses any write so an aborted operation leaves no partial update.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = stream;
    ram_wdata = calc_wdata;
    if (state == S_INIT) begin
      ram_we    = !rst_i;
      ram_addr  = init_cnt;
      ram_wdata = '{z: DEF_Z, w: DEF_W};
    end else if (state == S_CALC) begin
      ram_we = !rst_i && calc_wr;
    end
  end

  rand_state_ram #(
    .DEPTH (NSTREAM),
    .WIDTH (64),
    .AW    (SBITS)
  ) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_INIT;
      init_cnt <= '0;
      stream   <= '0;
      auto_en  <= 1'b0;
      op_we    <= 1'b0;
      op_off   <= 3'b0;
      op_dat   <= 32'b0;
      rd_data  <= 32'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + SBITS'(1);
          if (&init_cnt) state <= S_IDLE;
        end
        S_IDLE: begin
          if (req_i) begin
            op_we  <= we_i;
            op_off <= adr_i[4:2];
            op_dat <= dat_i;
            state  <= S_READ;
          end
        end
        S_READ: state <= S_CALC;
        S_CALC: begin
          rd_data <= calc_rdata;
          if (op_we && op_off == OFF_SEL)  stream  <= op_dat[SBITS-1:0];
          if (op_we && op_off == OFF_CTRL) auto_en <= op_dat[0];
          state <= S_ACK;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end

  assign stall_o = (state != S_IDLE);
  assign ack_o   = (state == S_ACK);
  assign dat_o   = ack_o ? rd_data : 32'b0;

endmodule

// File: tb/tb_random_mwc_ms.sv
// Self-checking bench for random_mwc_ms: directed scenarios plus randomized register
// traffic compared against an array-based arithmetic model of every stream.
module tb_random_mwc_ms;

  localparam int NS = 1024;
`ifdef RANDOM_MWC_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam logic [31:0] DZ = 32'h159A_55E5;
  localparam logic [31:0] DW = 32'h1F12_3BB5;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i  = 1'b0;
  logic [4:0]  adr_i = 5'b0;
  logic [31:0] dat_i = 32'b0;
  logic        stall_o;
  logic        ack_o;
  logic [31:0] dat_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] zm [NS];
  logic [31:0] wm [NS];
  int unsigned sel_m;
  bit          auto_m;

  random_mwc_ms dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .we_i    (we_i),
    .adr_i   (adr_i),
    .dat_i   (dat_i),
    .stall_o (stall_o),
    .ack_o   (ack_o),
    .dat_o   (dat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] x, input int unsigned m);
    longint unsigned t;
    t = longint'(m) * longint'(x % 65536) + longint'(x / 65536);
    return t[31:0];
  endfunction

  function automatic logic [31:0] m_out(input logic [31:0] z, input logic [31:0] w);
    longint unsigned t;
    t = longint'(z) * 65536 + longint'(w);
    return t[31:0];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin
      zm[i] = DZ;
      wm[i] = DW;
    end
    sel_m  = 0;
    auto_m = 1'b0;
  endfunction

  function automatic void m_advance();
    zm[sel_m] = m_step(zm[sel_m], 36969);
    wm[sel_m] = m_step(wm[sel_m], 18000);
  endfunction

  // Returns the expected read data of an operation and applies its side effects.
  function automatic logic [31:0] m_op(input bit w, input int off, input logic [31:0] d);
    logic [31:0] e;
    e = 32'b0;
    case (off)
      0: begin
        if (!w) e = m_out(zm[sel_m], wm[sel_m]);
        if (w || auto_m) m_advance();
      end
      1: if (w) sel_m = d % NS; else e = sel_m;
      2: if (w) zm[sel_m] = (d == 0) ? DZ : d;
      3: if (w) wm[sel_m] = (d == 0) ? DW : d;
      4: if (w) auto_m = d[0]; else e = {31'b0, auto_m};
      5: if (!w && RB) e = zm[sel_m];
      6: if (!w && RB) e = wm[sel_m];
      default: e = 32'b0;
    endcase
    return e;
  endfunction

  // Called at a negedge; ends at the negedge after the ack cycle.
  task automatic bus(input bit w, input int off, input logic [31:0] d, output logic [31:0] r);
    int n;
    int k;
    logic [1:0] lo;
    n = 0;
    while (stall_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (stall_o) check("accept_timeout", {31'b0, stall_o}, 32'd0);
    lo    = 2'($urandom_range(0, 3));
    req_i = 1'b1;
    we_i  = w;
    adr_i = {3'(off), lo};
    dat_i = d;
    @(negedge clk_i);
    req_i = 1'b0;
    k = 1;
    while (!ack_o && k < 8) begin
      @(negedge clk_i);
      k++;
    end
    check("ack_latency", 32'(k), 32'd3);
    r = dat_o;
    @(negedge clk_i);
  endtask

  task automatic op(input string tag, input bit w, input int off, input logic [31:0] d);
    logic [31:0] r;
    logic [31:0] e;
    bus(w, off, d, r);
    e = m_op(w, off, d);
    if (!w) check(tag, r, e);
  endtask

  task automatic rd_const(input string tag, input int off, input logic [31:0] c);
    logic [31:0] r;
    logic [31:0] e;
    bus(1'b0, off, 32'b0, r);
    e = m_op(1'b0, off, 32'b0);
    check(tag, r, c);
    check({tag, "_model"}, r, e);
  endtask

  // Entered at a negedge with rst_i already high; counts stall cycles after release.
  task automatic release_and_count(input string tag);
    int cnt;
    rst_i = 1'b0;
    m_reset();
    cnt = 0;
    while (stall_o && cnt < NS + 50) begin
      cnt++;
      @(negedge clk_i);
    end
    check(tag, 32'(cnt), 32'(NS));
  endtask

  initial begin
    logic [31:0] r;
    m_reset();
    repeat (3) @(negedge clk_i);
    check("rst_stall", {31'b0, stall_o}, 32'd1);
    check("rst_ack", {31'b0, ack_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);

    // Requests during init are dropped, not queued.
    rst_i = 1'b0;
    m_reset();
    req_i = 1'b1; we_i = 1'b1; adr_i = 5'h04; dat_i = 32'd3;
    begin
      int cnt;
      cnt = 0;
      while (stall_o && cnt < NS + 50) begin
        cnt++;
        if (cnt == NS - 2) req_i = 1'b0;
        @(negedge clk_i);
      end
      check("init_len", 32'(cnt), 32'(NS));
    end
    req_i = 1'b0; we_i = 1'b0;
    begin
      int acks;
      acks = 0;
      repeat (6) begin
        @(negedge clk_i);
        if (ack_o) acks++;
      end
      check("no_queued_ack", 32'(acks), 32'd0);
    end
    rd_const("sel_after_ignored", 1, 32'd0);
    rd_const("out_default", 0, 32'h74F7_3BB5);
    check("dat_idle_zero", dat_o, 32'd0);

    op("zseed1", 1'b1, 2, 32'd1);
    op("wseed1", 1'b1, 3, 32'd1);
    op("adv", 1'b1, 0, 32'd0);
    rd_const("out_after_adv", 0, 32'h9069_4650);

    op("sel5", 1'b1, 1, 32'd5);
    op("z5", 1'b1, 2, 32'd1);
    op("w5", 1'b1, 3, 32'd1);
    op("sel6", 1'b1, 1, 32'd6);
    rd_const("out_s6", 0, 32'h74F7_3BB5);
    op("sel5b", 1'b1, 1, 32'hFFFF_F005);
    rd_const("sel_dropped_bits", 1, 32'd5);
    rd_const("out_s5", 0, 32'h0001_0001);

    op("sel7", 1'b1, 1, 32'd7);
    op("z7", 1'b1, 2, 32'd1);
    op("w7", 1'b1, 3, 32'd1);
    op("auto_on", 1'b1, 4, 32'hFFFF_FFFF);
    rd_const("ctrl_rd", 4, 32'd1);
    rd_const("auto_rd1", 0, 32'h0001_0001);
    rd_const("auto_rd2", 0, 32'h9069_4650);
    op("auto_off", 1'b1, 4, 32'd0);

    op("zseed0", 1'b1, 2, 32'd0);
    rd_const("zrb", 5, RB ? DZ : 32'd0);
    op("wrb", 1'b0, 6, 32'd0);
    op("bad_off_wr", 1'b1, 7, 32'hDEAD_BEEF);
    rd_const("bad_off_rd", 7, 32'd0);

    for (int i = 0; i < 300; i++) begin
      int off;
      bit w;
      logic [31:0] d;
      off = $urandom_range(0, 7);
      w   = $urandom_range(0, 1) == 1;
      d   = $urandom;
      if (off == 2 || off == 3) begin
        w = 1'b1;
        if ($urandom_range(0, 3) == 0) d = 32'd0;
      end
      if (off == 1) d = (d & 32'hFFFF_F000) | 32'($urandom_range(0, 7));
      op("rand", w, off, d);
    end

    // Abort an advance in CALC with reset.
    op("sel3", 1'b1, 1, 32'd3);
    req_i = 1'b1; we_i = 1'b1; adr_i = 5'h00; dat_i = 32'd0;
    @(negedge clk_i);
    req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("abort_no_ack", {31'b0, ack_o}, 32'd0);
    check("abort_stall", {31'b0, stall_o}, 32'd1);
    release_and_count("reinit_len");
    rd_const("reinit_out", 0, 32'h74F7_3BB5);
    rd_const("reinit_sel", 1, 32'd0);
    rd_const("reinit_ctrl", 4, 32'd0);
    op("sel3b", 1'b1, 1, 32'd3);
    rd_const("reinit_s3", 0, 32'h74F7_3BB5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/random_mwc_ms.md
# random_mwc_ms

Parametrised multi-stream Marsaglia multiply-with-carry random number generator. It is the next generation of the single-parameter-set random peripheral. Stream count and multipliers are parameters. Per-stream state lives in one combined {z,w} RAM that is initialised by hardware after reset. The block adds zero-seed protection and an optional auto-advance-on-read mode. It sits behind the I/O bridge as a simple single-outstanding register slave.

## Interface
Parameters:
- NSTREAM, 1024: number of independent streams; power of two, 2..4096.
- SBITS, $clog2(NSTREAM): stream index width.
- Z_MULT, 36969 (decimal): z multiplier, 16-bit.
- W_MULT, 18000 (decimal): w multiplier, 16-bit.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  1  request valid; requester holds it until accepted.
- we_i  in  1  write when 1.
- adr_i  in  5  byte address; adr_i[4:2] selects the register.
- dat_i  in  32  write data.
- stall_o  out  1  block not in IDLE; a request is accepted only in a cycle where stall_o=0.
- ack_o  out  1  one-cycle response strobe, for reads and writes.
- dat_o  out  32  read data, valid while ack_o=1 and 0 otherwise.

## Operation
Registers:
- 0x00: read returns the current output; write advances the selected stream.
- 0x04: stream select, R/W, SBITS bits, zero-extended on read.
- 0x08: z seed, write.
- 0x0C: w seed, write.
- 0x10: control. Bit0 AUTO is R/W. Bits 31:1 read 0 and writes to them are ignored.
- 0x14 / 0x18: z / w readback, present only with the macro; otherwise they read 0.
- Other offsets: reads return 0, writes are ignored; ack is still given.

Arithmetic:
- z' = Z_MULT*z[15:0] + z[31:16]
- w' = W_MULT*w[15:0] + w[31:16]
- Both results are 32-bit and cannot overflow.
- Output = (z<<16)+w, taken mod 2^32.

Default seeds and zero-seed protection:
- Default z = 0x159A55E5, default w = 0x1F123BB5.
- A seed write of 0 stores the default value for that half instead.

Auto-advance:
- With AUTO=1, a read of 0x00 returns the pre-advance output and advances the stream in the same operation.

State RAM:
- NSTREAM x 64, synchronous read, one write port.
- Every operation is a read-modify-write of entry [stream].
- A z-only or w-only seed write preserves the other half.

FSM:
- INIT: write defaults to entry init_cnt, incrementing init_cnt; go to IDLE after entry NSTREAM-1.
- IDLE: on req_i, capture we/adr/dat and present RAM address = stream; go to READ.
- READ: RAM data valid at the end of the cycle; go to CALC.
- CALC: compute the next state and read data; write the RAM if needed (advance, seed, auto-advance); update stream/AUTO on their writes; go to ACK.
- ACK: ack_o=1 and dat_o driven; go to IDLE.

## Timing
Reset values:
- rst_i forces INIT, init_cnt=0, stream=0, AUTO=0.
- ack_o=0, dat_o=0, stall_o=1.

Reset mid-operation:
- The current operation is aborted; no ack and no partial RAM write.
- Initialisation restarts from entry 0.

Initialisation length:
- INIT occupies exactly NSTREAM cycles after the first cycle with rst_i=0.
- stall_o falls in cycle NSTREAM.

Request timing:
- A request accepted at cycle N gets ack_o at N+3.
- Throughput is one operation per 4 cycles.

Boundary conditions:
- A stream select written at N takes effect for requests accepted at N+4 or later; there is no hazard, because operations are serialised.
- req_i while stall_o=1 is ignored and not queued.
- Stream index wraps naturally; bits of dat_i above SBITS are dropped.

## Configuration
- RANDOM_MWC_READBACK_EN defined: 0x14/0x18 return the raw z/w of the selected stream, read in CALC.
- Undefined: those offsets read 0, and no readback mux logic is present.

## Structure
- Package random_mwc_pkg:
  - default seeds;
  - register offset constants;
  - FSM state enum {INIT, IDLE, READ, CALC, ACK};
  - a packed {z,w} state struct.
- Sub-module rand_state_ram: parameterised depth/width, synchronous-read BRAM; it is given a block RAM style attribute.

## Test plan
- Reset, wait NSTREAM cycles, read 0x00 on stream 0 -> 0x74F73BB5, with ack exactly 3 cycles after accept.
- Write z=1 and w=1, write 0x00, read 0x00 -> 0x90694650.
- Select stream 5 and seed it z=1, w=1; select stream 6 and read 0x00 -> 0x74F73BB5. Re-select stream 5 and read -> 0x00010001.
- With AUTO=1 on fresh z=1, w=1: first read -> 0x00010001, second read -> 0x90694650.
- With the macro defined: write z seed 0, read 0x14 -> 0x159A55E5, and 0x18 keeps the prior w.
- Assert rst_i during CALC of an advance: no ack, stall_o high for NSTREAM cycles, then stream 0 reads 0x74F73BB5.
